// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, ALU select codes, FSM states
// and the instruction layout.
package alu_sequencer_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  // loadi uses the low byte as an immediate, mov reads only SRC2.
  function automatic logic is_illegal(instr_t ins);
    logic bad;
    bad = (ins.op > OP_OR) || (ins.dest[7:3] != 5'd0);
    if ((ins.op != OP_LOADI) && (ins.op <= OP_OR)) begin
      if (ins.src2[7:3] != 5'd0) bad = 1'b1;
      if ((ins.op != OP_MOV) && (ins.src1[7:3] != 5'd0)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// 8-bit combinational ALU: pass DATA2, add, and, or. Results wrap modulo 256.
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
(
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] SELECT,
  output logic [7:0] RESULT
);

  always_comb begin
    RESULT = 8'h00;
    case (SELECT)
      SEL_PASS: RESULT = DATA2;
      SEL_ADD:  RESULT = DATA1 + DATA2;
      SEL_AND:  RESULT = DATA1 & DATA2;
      SEL_OR:   RESULT = DATA1 | DATA2;
      default:  RESULT = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an 8-bit ALU and an 8-entry
// register file; one instruction every three cycles.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic        WB_VALID,
  output logic [2:0]  WB_ADDR,
  output logic [7:0]  WB_DATA,
  output logic        ERROR,
  output logic        BUSY,
  output logic [7:0]  INSTR_COUNT
);

  state_e     state_q, state_d;
  instr_t     instr_q;
  logic [7:0] regs_q [NUM_REGS];
  logic       ready_en_q;
  logic       illegal_q;
  logic [2:0] wb_addr_q;
  logic [7:0] wb_data_q;
  logic [7:0] count_q;

  logic [7:0] rs1, rs2;
  logic [7:0] alu_data1, alu_data2, alu_result;
  logic [2:0] alu_sel;
  logic       exec_illegal;
  logic       handshake;

  assign rs1          = regs_q[instr_q.src1[2:0]];
  assign rs2          = regs_q[instr_q.src2[2:0]];
  assign exec_illegal = is_illegal(instr_q);
  assign handshake    = INSTR_VALID && INSTR_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (handshake) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ready_en_q keeps INSTR_READY low until the first edge after reset releases.
  always_comb begin
    INSTR_READY = (state_q == ST_IDLE) && ready_en_q;
    BUSY        = (state_q != ST_IDLE);
    WB_VALID    = (state_q == ST_WB) && !illegal_q;
    ERROR       = (state_q == ST_WB) && illegal_q;
  end

  always_comb begin
    alu_sel   = SEL_PASS;
    alu_data1 = rs1;
    alu_data2 = 8'h00;
    case (instr_q.op)
      OP_LOADI: alu_data2 = instr_q.src2;
      OP_MOV:   alu_data2 = rs2;
      OP_ADD:   begin alu_sel = SEL_ADD; alu_data2 = rs2;          end
      OP_SUB:   begin alu_sel = SEL_ADD; alu_data2 = ~rs2 + 8'd1;  end
      OP_AND:   begin alu_sel = SEL_AND; alu_data2 = rs2;          end
      OP_OR:    begin alu_sel = SEL_OR;  alu_data2 = rs2;          end
      default:  alu_data2 = 8'h00;
    endcase
  end

  alu_sequencer_alu u_alu (
    .DATA1  (alu_data1),
    .DATA2  (alu_data2),
    .SELECT (alu_sel),
    .RESULT (alu_result)
  );

  // The WB outputs are loaded when a legal result leaves EXEC and otherwise hold.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ready_en_q <= 1'b0;
      instr_q    <= '0;
      illegal_q  <= 1'b0;
      wb_addr_q  <= 3'd0;
      wb_data_q  <= 8'h00;
      count_q    <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      ready_en_q <= 1'b1;
      if (handshake) instr_q <= INSTR;
      if (state_q == ST_EXEC) begin
        illegal_q <= exec_illegal;
        if (!exec_illegal) begin
          wb_addr_q <= instr_q.dest[2:0];
          wb_data_q <= alu_result;
        end
      end
      if (WB_VALID) begin
        regs_q[wb_addr_q] <= wb_data_q;
        count_q           <= count_q + 8'd1;
      end
    end
  end

  assign WB_ADDR     = wb_addr_q;
  assign WB_DATA     = wb_data_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus reset, back-to-back and
// counter-wrap sequences.
module tb_alu_sequencer;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        WB_VALID;
  logic [2:0]  WB_ADDR;
  logic [7:0]  WB_DATA;
  logic        ERROR;
  logic        BUSY;
  logic [7:0]  INSTR_COUNT;

  int tests = 0;
  int fails = 0;

  alu_sequencer #(.NUM_REGS(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .WB_VALID    (WB_VALID),
    .WB_ADDR     (WB_ADDR),
    .WB_DATA     (WB_DATA),
    .ERROR       (ERROR),
    .BUSY        (BUSY),
    .INSTR_COUNT (INSTR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic        wbv;
    logic        err;
    logic [2:0]  addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after WB.
  task automatic run_instr(input logic [31:0] ins, output logic early, output logic wbv,
                           output logic err, output logic [2:0] addr, output logic [7:0] data,
                           output logic ready3);
    int n;
    n = 0;
    INSTR = ins;
    INSTR_VALID = 1'b1;
    while (!INSTR_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!INSTR_READY) begin
      chk("ready_timeout", {31'd0, INSTR_READY}, 32'd1);
      INSTR_VALID = 1'b0;
      early = 1'bx; wbv = 1'bx; err = 1'bx; addr = 'x; data = 'x; ready3 = 1'bx;
      return;
    end
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    INSTR = 32'hFFFF_FFFF;
    @(negedge CLK);
    early = WB_VALID | ERROR;
    @(negedge CLK);
    wbv = WB_VALID; err = ERROR; addr = WB_ADDR; data = WB_DATA;
    @(negedge CLK);
    ready3 = INSTR_READY;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic e, v, er, r3;
    logic [2:0] a;
    logic [7:0] d;
    logic [8:0] pat;
    int wbc, idx;
    logic [31:0] seq [3];

    vecs[0]  = '{32'h0001_00FF, 1'b1, 1'b0, 3'd1, 8'hFF}; // loadi R1,FF
    vecs[1]  = '{32'h0002_0001, 1'b1, 1'b0, 3'd2, 8'h01}; // loadi R2,01
    vecs[2]  = '{32'h0203_0102, 1'b1, 1'b0, 3'd3, 8'h00}; // add R3,R1,R2 wraps
    vecs[3]  = '{32'h0001_0032, 1'b1, 1'b0, 3'd1, 8'h32};
    vecs[4]  = '{32'h0002_003A, 1'b1, 1'b0, 3'd2, 8'h3A};
    vecs[5]  = '{32'h0304_0102, 1'b1, 1'b0, 3'd4, 8'hF8}; // sub
    vecs[6]  = '{32'h0405_0102, 1'b1, 1'b0, 3'd5, 8'h32}; // and
    vecs[7]  = '{32'h0506_0102, 1'b1, 1'b0, 3'd6, 8'h3A}; // or
    vecs[8]  = '{32'h0107_0004, 1'b1, 1'b0, 3'd7, 8'hF8}; // mov R7,R4
    vecs[9]  = '{32'h0701_0102, 1'b0, 1'b1, 3'd7, 8'hF8}; // bad opcode, outputs hold
    vecs[10] = '{32'h0008_0000, 1'b0, 1'b1, 3'd7, 8'hF8}; // bad dest
    vecs[11] = '{32'h0201_0109, 1'b0, 1'b1, 3'd7, 8'hF8}; // bad src2
    vecs[12] = '{32'h0000_FF05, 1'b1, 1'b0, 3'd0, 8'h05}; // loadi ignores src1
    vecs[13] = '{32'h0200_0004, 1'b1, 1'b0, 3'd0, 8'hFD}; // reads fresh R0

    RESET = 1'b0;
    INSTR = 32'h0;
    INSTR_VALID = 1'b0;
    #3 RESET = 1'b1;
    #1;
    chk("rst_ready",  {31'd0, INSTR_READY}, 32'd0);
    chk("rst_busy",   {31'd0, BUSY},        32'd0);
    chk("rst_wbv",    {31'd0, WB_VALID},    32'd0);
    chk("rst_err",    {31'd0, ERROR},       32'd0);
    chk("rst_addr",   {29'd0, WB_ADDR},     32'd0);
    chk("rst_data",   {24'd0, WB_DATA},     32'd0);
    chk("rst_count",  {24'd0, INSTR_COUNT}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("ready_low_after_release", {31'd0, INSTR_READY}, 32'd0);
    @(posedge CLK);
    #1 chk("ready_first_edge", {31'd0, INSTR_READY}, 32'd1);
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].ins, e, v, er, a, d, r3);
      $display("[TB] row %0d instr %08h wb_valid=%0b error=%0b addr=%0d data=%02h", i, vecs[i].ins, v, er, a, d);
      chk($sformatf("row%0d_early", i), {31'd0, e},  32'd0);
      chk($sformatf("row%0d_wbv", i),   {31'd0, v},  {31'd0, vecs[i].wbv});
      chk($sformatf("row%0d_err", i),   {31'd0, er}, {31'd0, vecs[i].err});
      chk($sformatf("row%0d_addr", i),  {29'd0, a},  {29'd0, vecs[i].addr});
      chk($sformatf("row%0d_data", i),  {24'd0, d},  {24'd0, vecs[i].data});
      chk($sformatf("row%0d_ready3", i), {31'd0, r3}, 32'd1);
    end
    chk("table_count", {24'd0, INSTR_COUNT}, 32'd11);

    // Reset in the EXEC cycle of loadi R1,0x55 (R1 currently holds 0x32).
    INSTR = 32'h0001_0055;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
    chk("abort_busy_exec", {31'd0, BUSY}, 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("abort_busy",  {31'd0, BUSY},        32'd0);
    chk("abort_count", {24'd0, INSTR_COUNT}, 32'd0);
    chk("abort_ready", {31'd0, INSTR_READY}, 32'd0);
    wbc = 0;
    repeat (3) begin
      @(negedge CLK);
      if (WB_VALID) wbc++;
    end
    chk("abort_no_wb", wbc, 32'd0);
    RESET = 1'b0;
    run_instr(32'h0102_0001, e, v, er, a, d, r3); // mov R2,R1
    $display("[TB] after abort mov R2,R1 wb_valid=%0b addr=%0d data=%02h", v, a, d);
    chk("abort_mov_wbv",  {31'd0, v}, 32'd1);
    chk("abort_mov_addr", {29'd0, a}, 32'd2);
    chk("abort_mov_data", {24'd0, d}, 32'h00);
    chk("abort_mov_count", {24'd0, INSTR_COUNT}, 32'd1);

    // Back-to-back with INSTR_VALID held high.
    do_reset();
    seq[0] = 32'h0001_0011;
    seq[1] = 32'h0002_0022;
    seq[2] = 32'h0203_0102;
    idx = 0;
    wbc = 0;
    INSTR = seq[0];
    INSTR_VALID = 1'b1;
    for (int k = 0; k < 9; k++) begin
      pat[k] = INSTR_READY;
      if (WB_VALID) wbc++;
      if (INSTR_READY) begin
        @(posedge CLK);
        #1;
        idx++;
        if (idx < 3) INSTR = seq[idx];
        else INSTR_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    $display("[TB] streaming ready pattern %09b wb pulses %0d count %0d", pat, wbc, INSTR_COUNT);
    chk("stream_ready_pattern", {23'd0, pat}, 32'b001001001);
    chk("stream_wb_pulses", wbc, 32'd3);
    chk("stream_count", {24'd0, INSTR_COUNT}, 32'd3);
    chk("stream_last_addr", {29'd0, WB_ADDR}, 32'd3);
    chk("stream_last_data", {24'd0, WB_DATA}, 32'h33);

    // Counter wrap after 256 legal instructions.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] imm;
      logic [2:0] rd;
      imm = 8'(i);
      rd = 3'(i);
      run_instr({8'h00, 5'd0, rd, 8'h00, imm}, e, v, er, a, d, r3);
      if (i == 254) chk("wrap_count_ff", {24'd0, INSTR_COUNT}, 32'hFF);
    end
    $display("[TB] wrap run done count %0d last data %02h", INSTR_COUNT, WB_DATA);
    chk("wrap_count_00", {24'd0, INSTR_COUNT}, 32'h00);
    chk("wrap_last_data", {24'd0, WB_DATA}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
